// File: rtl/ux607_pwmsched.sv
// ux607_pwmsched: four-channel PWM scheduler.
//
// A prescaled up-counter runs from 0 to PERIOD and is compared against four
// per-channel compare values to produce registered PWM outputs.
//
// Ports:
//   clock          - single clock for all state
//   reset          - synchronous, active-high reset
//   io_wr_en       - register write strobe
//   io_wr_addr     - write address: 0=CTRL 1=PERIOD 2..5=CMP0..CMP3
//   io_wr_data     - write data; CTRL bit0=EN, bits[SCALE_W+3:4]=SCALE
//   io_rd_addr     - read address: same map plus 6=COUNT
//   io_rd_data     - combinational read data (unmapped addresses read 0)
//   io_pwm_port_n  - registered PWM outputs, n = 0..3
//   io_wrap        - one-cycle registered pulse on each counter wrap
//
// Build option: define UX607_PWM_SHADOW_EN to double-buffer the compare
// registers so duty changes only take effect at a wrap (or while disabled).
module ux607_pwmsched #(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned SCALE_W = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               io_wr_en,
  input  logic [2:0]         io_wr_addr,
  input  logic [CNT_W-1:0]   io_wr_data,
  input  logic [2:0]         io_rd_addr,
  output logic [CNT_W-1:0]   io_rd_data,
  output logic               io_pwm_port_0,
  output logic               io_pwm_port_1,
  output logic               io_pwm_port_2,
  output logic               io_pwm_port_3,
  output logic               io_wrap
);

  // Prescaler width: enough for the largest SCALE, capped at 15 bits.
  localparam int unsigned ScaleMax = (1 << SCALE_W) - 1;
  localparam int unsigned PsW = (ScaleMax > 15) ? 15 : ((ScaleMax < 1) ? 1 : ScaleMax);

  logic                     en_q, en_d;
  logic [SCALE_W-1:0]       scale_q, scale_d;
  logic [CNT_W-1:0]         period_q, period_d;
  logic [3:0][CNT_W-1:0]    cmp_wr_q, cmp_wr_d;
  logic [3:0][CNT_W-1:0]    cmp_act;
  logic [PsW-1:0]           ps_q, ps_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [3:0]               pwm_q, pwm_d;
  logic                     wrap_q, wrap_d;

  logic                     ctrl_wr;
  logic                     load;
  logic                     tick;
  logic [SCALE_W-1:0]       scale_eff;
  logic [PsW:0]             ps_max;

  // SCALE values beyond the prescaler width saturate at the widest divide.
  assign scale_eff = (32'(scale_q) > PsW) ? SCALE_W'(PsW) : scale_q;
  assign ps_max    = ({{PsW{1'b0}}, 1'b1} << scale_eff) - 1'b1;
  assign tick      = en_q && ({1'b0, ps_q} == ps_max);
  assign ctrl_wr   = io_wr_en && (io_wr_addr == 3'd0);

  always_comb begin
    en_d     = en_q;
    scale_d  = scale_q;
    period_d = period_q;
    cmp_wr_d = cmp_wr_q;
    ps_d     = ps_q;
    cnt_d    = cnt_q;
    wrap_d   = 1'b0;
    load     = 1'b0;

    if (ctrl_wr) begin
      en_d    = io_wr_data[0];
      scale_d = io_wr_data[SCALE_W+3:4];
    end
    if (io_wr_en && (io_wr_addr == 3'd1)) begin
      period_d = io_wr_data;
    end
    for (int n = 0; n < 4; n++) begin
      if (io_wr_en && (io_wr_addr == 3'(n + 2))) begin
        cmp_wr_d[n] = io_wr_data;
      end
    end

    // A disabling write beats a coincident tick: no wrap is generated.
    if (!en_q || (ctrl_wr && !io_wr_data[0])) begin
      ps_d  = '0;
      cnt_d = '0;
    end else if (tick) begin
      ps_d = '0;
      // >= so that lowering PERIOD below cnt ends the period at the next tick.
      if (cnt_q >= period_q) begin
        cnt_d  = '0;
        wrap_d = 1'b1;
        load   = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      ps_d = ps_q + 1'b1;
    end

    for (int n = 0; n < 4; n++) begin
      pwm_d[n] = en_q && (cnt_q < cmp_act[n]);
    end
  end

`ifdef UX607_PWM_SHADOW_EN
  logic [3:0][CNT_W-1:0] cmp_act_q, cmp_act_d;

  // Loading from the next-state written copy lets a same-cycle write bypass.
  always_comb begin
    cmp_act_d = cmp_act_q;
    if (load || !en_q) begin
      cmp_act_d = cmp_wr_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cmp_act_q <= '0;
    end else begin
      cmp_act_q <= cmp_act_d;
    end
  end

  assign cmp_act = cmp_act_q;
`else
  assign cmp_act = cmp_wr_q;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      en_q     <= 1'b0;
      scale_q  <= '0;
      period_q <= '0;
      cmp_wr_q <= '0;
      ps_q     <= '0;
      cnt_q    <= '0;
      pwm_q    <= '0;
      wrap_q   <= 1'b0;
    end else begin
      en_q     <= en_d;
      scale_q  <= scale_d;
      period_q <= period_d;
      cmp_wr_q <= cmp_wr_d;
      ps_q     <= ps_d;
      cnt_q    <= cnt_d;
      pwm_q    <= pwm_d;
      wrap_q   <= wrap_d;
    end
  end

  always_comb begin
    io_rd_data = '0;
    unique case (io_rd_addr)
      3'd0: begin
        io_rd_data[0]           = en_q;
        io_rd_data[SCALE_W+3:4] = scale_q;
      end
      3'd1:    io_rd_data = period_q;
      3'd2:    io_rd_data = cmp_wr_q[0];
      3'd3:    io_rd_data = cmp_wr_q[1];
      3'd4:    io_rd_data = cmp_wr_q[2];
      3'd5:    io_rd_data = cmp_wr_q[3];
      3'd6:    io_rd_data = cnt_q;
      default: io_rd_data = '0;
    endcase
  end

  assign io_pwm_port_0 = pwm_q[0];
  assign io_pwm_port_1 = pwm_q[1];
  assign io_pwm_port_2 = pwm_q[2];
  assign io_pwm_port_3 = pwm_q[3];
  assign io_wrap       = wrap_q;

endmodule
